// File: rtl/aux_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : aux_uart_tx
// Brief    : Aux-bus responder exposing a memory-mapped 8N1 UART transmitter
//            with a byte FIFO, a programmable baud divisor and a sticky
//            overflow flag. The registers are read back over the tri-state
//            aux data bus.
// Revision : 1.0 - initial release
// ============================================================================
module aux_uart_tx #(
    parameter int                        AUX_ADDR_WIDTH = 16,
    parameter logic [AUX_ADDR_WIDTH-1:0] BASE_ADDR      = 16'h0000,
    parameter int                        FIFO_DEPTH     = 8,
    parameter logic [15:0]               DEFAULT_DIV    = 16'd433
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      clk_en_i,
    input  logic [AUX_ADDR_WIDTH-1:0] aux_adr_i,
    inout  wire  [7:0]                aux_dat_io,
    input  logic                      aux_we_i,
    input  logic                      aux_re_i,
    output logic                      tx_o
);

    localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0]         c_DEPTH    = 4'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    localparam logic [1:0] c_REG_DATA = 2'd0;
    localparam logic [1:0] c_REG_STAT = 2'd1;
    localparam logic [1:0] c_REG_DIVL = 2'd2;
    localparam logic [1:0] c_REG_DIVH = 2'd3;

    // State
    logic [1:0]         state_q,    state_d;
    logic [15:0]        cnt_q,      cnt_d;
    logic [7:0]         shift_q,    shift_d;
    logic [2:0]         bit_idx_q,  bit_idx_d;
    logic               tx_q,       tx_d;
    logic [15:0]        div_q,      div_d;
    logic               overflow_q, overflow_d;
    logic [3:0]         count_q,    count_d;
    logic [c_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    // Bus decode
    logic [AUX_ADDR_WIDTH-1:0] w_off;
    logic                      w_hit;
    logic [1:0]                w_sel;
    logic [7:0]                w_wdata;
    logic                      w_wr_data, w_wr_stat, w_wr_divl, w_wr_divh;
    logic                      w_full, w_empty, w_busy;
    logic                      w_push, w_pop, w_ovf_set;
    logic [7:0]                w_status;
    logic [7:0]                w_rdata;

    // The window check relies on modular subtraction: anything below the
    // base wraps to a large offset and misses.
    assign w_off     = aux_adr_i - BASE_ADDR;
    assign w_hit     = (w_off[AUX_ADDR_WIDTH-1:2] == '0);
    assign w_sel     = w_off[1:0];
    assign w_wdata   = aux_dat_io;

    assign w_wr_data = w_hit && aux_we_i && (w_sel == c_REG_DATA);
    assign w_wr_stat = w_hit && aux_we_i && (w_sel == c_REG_STAT);
    assign w_wr_divl = w_hit && aux_we_i && (w_sel == c_REG_DIVL);
    assign w_wr_divh = w_hit && aux_we_i && (w_sel == c_REG_DIVH);

    assign w_full    = (count_q == c_DEPTH);
    assign w_empty   = (count_q == 4'd0);
    assign w_busy    = (state_q != c_ST_IDLE);

    // A push into a full FIFO is dropped even if a pop frees a slot in the
    // same cycle; fullness is judged on the registered count only.
    assign w_push    = w_wr_data && !w_full;
    assign w_ovf_set = w_wr_data && w_full;

    assign w_status  = {overflow_q, count_q, w_busy, w_empty, w_full};

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Read mux for the tri-state bus
    always_comb begin
        w_rdata = 8'h00;
        case (w_sel)
            c_REG_DATA: w_rdata = 8'h00;
            c_REG_STAT: w_rdata = w_status;
            c_REG_DIVL: w_rdata = div_q[7:0];
            c_REG_DIVH: w_rdata = div_q[15:8];
            default:    w_rdata = 8'h00;
        endcase
    end

    assign aux_dat_io = (aux_re_i && !aux_we_i && w_hit) ? w_rdata : 8'hzz;
    assign tx_o       = tx_q;

    // Transmit sequencer: one bit per DIV+1 enabled cycles, divisor sampled
    // only at bit boundaries so a mid-frame write never stretches a bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        w_pop     = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = div_q;
                    tx_d    = 1'b0;
                    state_d = c_ST_START;
                end
            end
            c_ST_START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d     = div_q;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d = div_q;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = c_ST_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            c_ST_STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!w_empty) begin
                    // Chain straight into the next start bit, no idle gap
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = div_q;
                    tx_d    = 1'b0;
                    state_d = c_ST_START;
                end else begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping, divisor and overflow register next-state
    always_comb begin
        wr_ptr_d   = w_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + {3'b000, w_push} - {3'b000, w_pop};
        overflow_d = overflow_q;
        if (w_ovf_set) begin
            overflow_d = 1'b1;
        end else if (w_wr_stat && w_wdata[7]) begin
            overflow_d = 1'b0;
        end
        div_d = div_q;
        if (w_wr_divl) begin
            div_d[7:0] = w_wdata;
        end
        if (w_wr_divh) begin
            div_d[15:8] = w_wdata;
        end
    end

    // State registers; everything freezes while the clock enable is low
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= c_ST_IDLE;
            cnt_q      <= 16'd0;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
            div_q      <= DEFAULT_DIV;
            overflow_q <= 1'b0;
            count_q    <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else if (clk_en_i) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            div_q      <= div_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate validity
    always_ff @(posedge clk_i) begin
        if (clk_en_i && w_push) begin
            mem_q[wr_ptr_q] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aux_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_aux_uart_tx
// Brief    : Directed bench for aux_uart_tx: register access, bus tri-state,
//            frame timing, FIFO overflow, back-to-back frames, clock enable
//            gating and reset mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aux_uart_tx;

    localparam logic [15:0] c_A_DATA = 16'h0010;
    localparam logic [15:0] c_A_STAT = 16'h0011;
    localparam logic [15:0] c_A_DIVL = 16'h0012;
    localparam logic [15:0] c_A_DIVH = 16'h0013;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic [15:0] aux_adr_i;
    logic        aux_we_i;
    logic        aux_re_i;
    logic        tx_o;
    logic        drv_en;
    logic [7:0]  drv_data;
    tri1  [7:0]  aux_bus;

    int n_tests = 0;
    int n_fail  = 0;

    assign aux_bus = drv_en ? drv_data : 8'hzz;

    aux_uart_tx #(
        .AUX_ADDR_WIDTH(16),
        .BASE_ADDR     (16'h0010),
        .FIFO_DEPTH    (8),
        .DEFAULT_DIV   (16'd433)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clk_en_i  (clk_en_i),
        .aux_adr_i (aux_adr_i),
        .aux_dat_io(aux_bus),
        .aux_we_i  (aux_we_i),
        .aux_re_i  (aux_re_i),
        .tx_o      (tx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge and the
    // task returns at the next negedge.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        aux_adr_i = a;
        drv_data  = d;
        drv_en    = 1'b1;
        aux_we_i  = 1'b1;
        @(negedge clk_i);
        aux_we_i  = 1'b0;
        drv_en    = 1'b0;
    endtask

    // Combinational read, finishes well before the next posedge
    task automatic peek(input logic [15:0] a, output logic [7:0] d);
        aux_adr_i = a;
        aux_re_i  = 1'b1;
        #1;
        d = aux_bus;
        aux_re_i  = 1'b0;
    endtask

    initial begin
        logic [7:0]   rd;
        logic [9:0]   frame;
        logic [63:0]  obs, exp;
        logic [127:0] samp;
        logic [7:0]   t2_bytes [10];
        logic [9:0]   fobs;
        logic [7:0]   busy_mid;
        bit           found;

        t2_bytes = '{8'h01, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h99};

        reset_i   = 1'b1;
        clk_en_i  = 1'b1;
        aux_adr_i = 16'h0000;
        aux_we_i  = 1'b0;
        aux_re_i  = 1'b0;
        drv_en    = 1'b0;
        drv_data  = 8'h00;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        // ---------------- reset state ----------------
        check("rst_tx", tx_o, 1'b1);
        peek(c_A_STAT, rd); check("rst_status", rd, 8'h02);
        peek(c_A_DIVL, rd); check("rst_divl", rd, 8'hB1);
        peek(c_A_DIVH, rd); check("rst_divh", rd, 8'h01);
        aux_adr_i = c_A_STAT; #1; check("rst_bus_z", aux_bus, 8'hFF);

        // ---------------- divisor readback and bus tri-state ----------------
        bus_write(c_A_DIVL, 8'h34);
        bus_write(c_A_DIVH, 8'h12);
        peek(c_A_DIVL, rd); check("divl_rb", rd, 8'h34);
        peek(c_A_DIVH, rd); check("divh_rb", rd, 8'h12);
        peek(c_A_DATA, rd); check("data_rd_zero", rd, 8'h00);
        aux_adr_i = c_A_DIVL; aux_re_i = 1'b0; #1;
        check("z_no_re", aux_bus, 8'hFF);
        peek(16'h0014, rd); check("z_above_win", rd, 8'hFF);
        peek(16'h000F, rd); check("z_below_win", rd, 8'hFF);
        aux_adr_i = c_A_DIVL; aux_re_i = 1'b1; aux_we_i = 1'b1; #1;
        check("z_during_we", aux_bus, 8'hFF);
        aux_re_i = 1'b0; aux_we_i = 1'b0;
        @(negedge clk_i);

        // ---------------- DIV=3, single 8'hA5 frame ----------------
        bus_write(c_A_DIVL, 8'h03);
        bus_write(c_A_DIVH, 8'h00);
        bus_write(c_A_DATA, 8'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        obs = '0; exp = '0; busy_mid = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            obs[i] = tx_o;
            exp[i] = frame[i / 4];
            if (i == 39) peek(c_A_STAT, busy_mid);
        end
        check("a5_wave", obs, exp);
        check("a5_busy_end", busy_mid, 8'h06);
        @(negedge clk_i);
        check("a5_tx_idle", tx_o, 1'b1);
        peek(c_A_STAT, rd); check("a5_status_after", rd, 8'h02);

        // ---------------- DIV=1000, 10 bytes, overflow ----------------
        bus_write(c_A_DIVL, 8'hE8);
        bus_write(c_A_DIVH, 8'h03);
        for (int i = 0; i < 10; i++) bus_write(c_A_DATA, t2_bytes[i]);
        peek(c_A_STAT, rd); check("ovf_status", rd, 8'hC5);
        bus_write(c_A_STAT, 8'h80);
        peek(c_A_STAT, rd); check("ovf_cleared", rd, 8'h45);
        // Speed up: new divisor takes effect at the end of the current start bit
        bus_write(c_A_DIVL, 8'h00);
        bus_write(c_A_DIVH, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk_i);
            if (tx_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("ovf_start_end_seen", found, 1'b1);
        samp = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            samp[i] = tx_o;
        end
        check("ovf_frame0_tail", samp[7:0], {1'b1, t2_bytes[0][7:1]});
        for (int f = 0; f < 8; f++) begin
            for (int j = 0; j < 10; j++) fobs[j] = samp[8 + 10 * f + j];
            check($sformatf("ovf_frame%0d", f + 1), fobs, {1'b1, t2_bytes[f + 1], 1'b0});
        end
        check("ovf_no_10th", samp[99:88], 12'hFFF);
        peek(c_A_STAT, rd); check("ovf_drained", rd, 8'h02);

        // ---------------- DIV=0, back-to-back 00 / FF ----------------
        bus_write(c_A_DATA, 8'h00);
        bus_write(c_A_DATA, 8'hFF);
        obs = '0;
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk_i);
            obs[i] = tx_o;
        end
        check("div0_b2b", obs, {43'd0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0});

        // ---------------- clock enable toggling, DIV=1 ----------------
        bus_write(c_A_DIVL, 8'h01);
        bus_write(c_A_DATA, 8'h4B);
        frame = {1'b1, 8'h4B, 1'b0};
        obs = '0; exp = '0;
        for (int i = 0; i < 40; i++) begin
            clk_en_i = (i % 2 == 0);
            @(negedge clk_i);
            obs[i] = tx_o;
            exp[i] = frame[i / 4];
        end
        clk_en_i = 1'b1;
        check("cken_wave", obs, exp);
        @(negedge clk_i);
        peek(c_A_STAT, rd); check("cken_idle", rd, 8'h02);
        clk_en_i = 1'b0;
        bus_write(c_A_DIVL, 8'h77);
        clk_en_i = 1'b1;
        peek(c_A_DIVL, rd); check("cken_write_frozen", rd, 8'h01);

        // ---------------- reset during DATA bit 4 ----------------
        bus_write(c_A_DIVL, 8'h03);
        bus_write(c_A_DATA, 8'h2C);
        bus_write(c_A_DATA, 8'h11);
        bus_write(c_A_DATA, 8'h22);
        bus_write(c_A_DATA, 8'h33);
        repeat (19) @(negedge clk_i);
        check("rstmid_bit4", tx_o, 1'b0);
        peek(c_A_STAT, rd); check("rstmid_status_before", rd, 8'h1C);
        reset_i = 1'b1;
        #1;
        check("rstmid_tx_async", tx_o, 1'b1);
        peek(c_A_STAT, rd); check("rstmid_status_in_rst", rd, 8'h02);
        @(negedge clk_i);
        reset_i = 1'b0;
        obs = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            obs[i] = tx_o;
        end
        check("rstmid_no_frames", obs, {24'd0, 40'hFF_FFFF_FFFF});
        peek(c_A_STAT, rd); check("rstmid_status_after", rd, 8'h02);
        peek(c_A_DIVL, rd); check("rstmid_div_reset", rd, 8'hB1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aux_uart_tx.md
Name: aux_uart_tx

Overview:
Aux-bus responder peripheral for the risc16f84 core: decodes the core's auxiliary address/data/strobe bus and exposes a memory-mapped 8N1 UART transmitter.
- Byte writes from firmware are queued in a FIFO and serialised on tx_o at a programmable baud rate.
- Status and divisor registers are readable back over the tri-state aux data bus.
- Sits beside the core on the aux bus, same clock and clock enable.

Parameters:
AUX_ADDR_WIDTH, 16, aux address bus width
BASE_ADDR, 16'h0000, address of register 0; block decodes BASE_ADDR..BASE_ADDR+3
FIFO_DEPTH, 8, TX FIFO entries (power of 2, max 8)
DEFAULT_DIV, 16'd433, divisor reset value

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous reset, active-high
clk_en_i  in  1  clock enable qualifying all sequential updates
aux_adr_i  in  AUX_ADDR_WIDTH  aux address from core
aux_dat_io  inout  8  aux data bus, tri-state bidirectional
aux_we_i  in  1  aux write strobe (H active)
aux_re_i  in  1  aux read strobe (H active)
tx_o  out  1  serial output, idle high

Behaviour:
- Reset (async, reset_i=1) sets:
  - tx_o=1, FSM=IDLE, FIFO empty, overflow=0, DIV=DEFAULT_DIV, aux_dat_io=Z.
- All register/FIFO/FSM updates occur on posedge clk_i only when clk_en_i=1. With clk_en_i=0, state is frozen and tx_o holds.
- Register map, offset from BASE_ADDR:
  - 0 DATA: write pushes byte; read returns 8'h00.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bits[6:3] count 0..8, bit7 overflow (sticky). Writing bit7=1 clears overflow; other bits are ignored.
  - 2 DIVL, 3 DIVH: divisor[7:0]/[15:8], read/write.
- Write: hit && aux_we_i sampled at clock edge. Writes outside the window are ignored.
- Read: combinational. aux_dat_io is driven with the selected register only while aux_re_i=1 && aux_we_i=0 && hit; otherwise Z. No read side effects.
- Push when full: byte dropped, overflow<=1. This applies even if a pop occurs the same cycle.
- Push and pop in the same cycle when not full: both take effect, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty at an enabled edge: pop head into shift register, baud counter<=DIV, enter START. tx_o=0 from that edge.
  - Every bit lasts DIV+1 enabled cycles. Counter decrements to 0, then reloads DIV at the bit boundary.
  - START -> DATA: 8 bits, LSB first, tx_o=shift[0], shift right each boundary, bit index 0..7.
  - DATA (after bit 7) -> STOP: tx_o=1 for one bit period.
  - STOP end: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- DIV write mid-frame: current bit period is unaffected; new value loads at the next bit boundary. DIV=0 gives a 1-clock bit.
- Reset mid-frame: tx_o returns high immediately (async), the frame is abandoned and the FIFO is flushed.
- Count arithmetic is width 4, saturating impossible by construction (0..FIFO_DEPTH). FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- DIV=3, write 8'hA5 to DATA -> tx_o low 4 clk, then 1,0,1,0,0,1,0,1 each 4 clk, then high 4 clk. busy=1 throughout the frame, STATUS reads 8'h02 after.
- DIV=1000, write 10 bytes back-to-back -> first byte shifting, count=8, full=1, overflow=1, 10th byte never transmitted. Write STATUS 8'h80 -> overflow=0.
- Write DIVL=8'h34, DIVH=8'h12 -> readback 8'h34/8'h12. aux_dat_io=Z when aux_re_i=0, when the address is outside the window, and during aux_we_i.
- DIV=0, write 8'h00 then 8'hFF -> two 10-clk frames with no gap between STOP and next START.
- clk_en_i toggled 1/0 alternately mid-frame -> each bit lasts (DIV+1) enabled cycles, i.e. 2x wall clocks, and the waveform shape is otherwise unchanged.
- Assert reset_i during DATA bit 4 with 3 bytes queued -> tx_o=1 same cycle, STATUS=8'h02, no further frames after release.
